wave_sweep_ctrl: RTL and testbench

//  Command-driven sequencer for wave_gen: accepts one sweep command, then holds each phase step for a

---
 rtl/wave_sweep_ctrl.sv | 161 ++++++++++++++++
 tb/tb_wave_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sweep_ctrl.sv
// Command-driven phase-step sequencer for wave_gen: latches one sweep command, then
// walks the phase step from start toward stop, holding each value for a programmable dwell.
module wave_sweep_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int PSW     = $clog2(DEPTH),
  parameter int DWELL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [PSW-1:0]     i_cmd_start_step,
  input  logic [PSW-1:0]     i_cmd_stop_step,
  input  logic [PSW-1:0]     i_cmd_inc,
  input  logic [DWELL_W-1:0] i_cmd_dwell,
  input  logic               i_cmd_repeat,
  input  logic               i_cmd_duty,
  input  logic [PSW-1:0]     i_cmd_gain,
  input  logic               i_abort,
  output logic [PSW-1:0]     o_wave_phase_step,
  output logic               o_sel_duty_cycle,
  output logic [PSW-1:0]     o_gain,
  output logic               o_wave_en,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [PSW-1:0]     phase_q, phase_d;
  logic [PSW-1:0]     start_q, start_d;
  logic [PSW-1:0]     stop_q, stop_d;
  logic [PSW-1:0]     inc_q, inc_d;
  logic [PSW-1:0]     gain_q, gain_d;
  logic               duty_q, duty_d;
  logic               rep_q, rep_d;
  logic               down_q, down_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] reload_q, reload_d;

  logic               accept;
  logic [PSW:0]       sum_ext;
  logic [PSW:0]       diff_ext;
  logic [PSW-1:0]     next_step;
  logic               sweep_end;

  assign accept = (state_q == ST_IDLE) && !i_abort && i_cmd_valid;

  // One extra bit catches carry/borrow so the step never wraps modulo DEPTH.
  assign sum_ext   = {1'b0, phase_q} + {1'b0, inc_q};
  assign diff_ext  = {1'b0, phase_q} - {1'b0, inc_q};
  assign next_step = down_q ? diff_ext[PSW-1:0] : sum_ext[PSW-1:0];

  always_comb begin
    if (inc_q == '0) begin
      sweep_end = 1'b0;
    end else if (down_q) begin
      sweep_end = diff_ext[PSW] || (diff_ext[PSW-1:0] < stop_q);
    end else begin
      sweep_end = sum_ext[PSW] || (sum_ext[PSW-1:0] > stop_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset clears every register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q  <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      inc_q    <= '0;
      gain_q   <= '0;
      duty_q   <= 1'b0;
      rep_q    <= 1'b0;
      down_q   <= 1'b0;
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      phase_q  <= phase_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      inc_q    <= inc_d;
      gain_q   <= gain_d;
      duty_q   <= duty_d;
      rep_q    <= rep_d;
      down_q   <= down_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold default first, so no path can infer a latch.
    state_d  = state_q;
    phase_d  = phase_q;
    start_d  = start_q;
    stop_d   = stop_q;
    inc_d    = inc_q;
    gain_d   = gain_q;
    duty_d   = duty_q;
    rep_d    = rep_q;
    down_d   = down_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_DWELL;
          phase_d  = i_cmd_start_step;
          start_d  = i_cmd_start_step;
          stop_d   = i_cmd_stop_step;
          inc_d    = i_cmd_inc;
          gain_d   = i_cmd_gain;
          duty_d   = i_cmd_duty;
          rep_d    = i_cmd_repeat;
          down_d   = i_cmd_start_step > i_cmd_stop_step;
          reload_d = (i_cmd_dwell == '0) ? '0 : i_cmd_dwell - DWELL_W'(1);
          cnt_d    = (i_cmd_dwell == '0) ? '0 : i_cmd_dwell - DWELL_W'(1);
        end
      end
      ST_DWELL: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          // Last cycle of the dwell: the next step is decided here so it appears on time.
          cnt_d = reload_q;
          if (!sweep_end) begin
            phase_d = next_step;
          end else if (rep_q) begin
            phase_d = start_q;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready       = (state_q == ST_IDLE) && !i_abort;
    o_wave_phase_step = phase_q;
    o_sel_duty_cycle  = duty_q;
    o_gain            = gain_q;
    o_wave_en         = (state_q == ST_DWELL);
    o_busy            = (state_q != ST_IDLE);
    o_done            = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_wave_sweep_ctrl.sv
// Directed bench for wave_sweep_ctrl: a table of one-shot sweeps with hand-computed step
// sequences, plus sequences for repeat, abort, constant tone and asynchronous reset.
module tb_wave_sweep_ctrl;

  localparam int PSW     = 10;
  localparam int DWELL_W = 16;

  logic               clk;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [PSW-1:0]     cmd_start;
  logic [PSW-1:0]     cmd_stop;
  logic [PSW-1:0]     cmd_inc;
  logic [DWELL_W-1:0] cmd_dwell;
  logic               cmd_repeat;
  logic               cmd_duty;
  logic [PSW-1:0]     cmd_gain;
  logic               abort;
  logic [PSW-1:0]     phase;
  logic               duty;
  logic [PSW-1:0]     gain;
  logic               wave_en;
  logic               busy;
  logic               done;

  int n_checks = 0;
  int n_errors = 0;

  wave_sweep_ctrl #(.DEPTH(1024), .PSW(PSW), .DWELL_W(DWELL_W)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_cmd_valid       (cmd_valid),
    .o_cmd_ready       (cmd_ready),
    .i_cmd_start_step  (cmd_start),
    .i_cmd_stop_step   (cmd_stop),
    .i_cmd_inc         (cmd_inc),
    .i_cmd_dwell       (cmd_dwell),
    .i_cmd_repeat      (cmd_repeat),
    .i_cmd_duty        (cmd_duty),
    .i_cmd_gain        (cmd_gain),
    .i_abort           (abort),
    .o_wave_phase_step (phase),
    .o_sel_duty_cycle  (duty),
    .o_gain            (gain),
    .o_wave_en         (wave_en),
    .o_busy            (busy),
    .o_done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PSW-1:0]     start;
    logic [PSW-1:0]     stop;
    logic [PSW-1:0]     inc;
    logic [DWELL_W-1:0] dwell;
    logic               duty;
    logic [PSW-1:0]     gain;
    int                 n_steps;
    logic [PSW-1:0]     exp_step [4];
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(int s, int p, int i, int d, int du, int g, int n,
                              int e0, int e1, int e2, int e3);
    vec_t v;
    v.start       = PSW'(s);
    v.stop        = PSW'(p);
    v.inc         = PSW'(i);
    v.dwell       = DWELL_W'(d);
    v.duty        = du[0];
    v.gain        = PSW'(g);
    v.n_steps     = n;
    v.exp_step[0] = PSW'(e0);
    v.exp_step[1] = PSW'(e1);
    v.exp_step[2] = PSW'(e2);
    v.exp_step[3] = PSW'(e3);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) break;
    end
    if (k == 50) check("ready_timeout", 32'(cmd_ready), 1);
  endtask

  task automatic issue(input vec_t v, input logic rep);
    wait_ready();
    @(posedge clk);
    #1;
    cmd_valid  = 1'b1;
    cmd_start  = v.start;
    cmd_stop   = v.stop;
    cmd_inc    = v.inc;
    cmd_dwell  = v.dwell;
    cmd_duty   = v.duty;
    cmd_gain   = v.gain;
    cmd_repeat = rep;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_oneshot(input vec_t v, input int idx);
    int dw;
    dw = (v.dwell == 0) ? 1 : int'(v.dwell);
    issue(v, 1'b0);
    for (int s = 0; s < v.n_steps; s++) begin
      for (int c = 0; c < dw; c++) begin
        @(negedge clk);
        check($sformatf("v%0d_step%0d_c%0d", idx, s, c), 32'(phase), 32'(v.exp_step[s]));
        check($sformatf("v%0d_en", idx), {wave_en, busy, done}, 3'b110);
      end
    end
    check($sformatf("v%0d_gain", idx), 32'(gain), 32'(v.gain));
    check($sformatf("v%0d_duty", idx), 32'(duty), 32'(v.duty));
    @(negedge clk);
    check($sformatf("v%0d_done", idx), {wave_en, busy, done}, 3'b011);
    check($sformatf("v%0d_done_hold", idx), 32'(phase), 32'(v.exp_step[v.n_steps-1]));
    @(negedge clk);
    check($sformatf("v%0d_idle", idx), {wave_en, busy, done, cmd_ready}, 4'b0001);
    check($sformatf("v%0d_idle_hold", idx), 32'(phase), 32'(v.exp_step[v.n_steps-1]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vec_t rv;
    logic [PSW-1:0] rep_exp [9];

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_start = '0; cmd_stop = '0; cmd_inc = '0;
    cmd_dwell = '0; cmd_repeat = 1'b0; cmd_duty = 1'b0; cmd_gain = '0; abort = 1'b0;

    vecs[0] = mk(10,   40,  10, 3, 1, 123, 4, 10,   20, 30, 40);
    vecs[1] = mk(0,    25,  10, 1, 0, 5,   3, 0,    10, 20, 0);
    vecs[2] = mk(1000, 1023, 30, 1, 1, 1023, 1, 1000, 0, 0,  0);
    vecs[3] = mk(100,  40,  30, 0, 0, 77,  3, 100,  70, 40, 0);
    vecs[4] = mk(20,   0,   15, 2, 1, 9,   2, 20,   5,  0,  0);
    vecs[5] = mk(7,    7,   3,  1, 0, 300, 1, 7,    0,  0,  0);

    #12;
    check("rst_outputs", {phase, gain, duty, wave_en, busy, done}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 1);

    for (int i = 0; i < 6; i++) run_oneshot(vecs[i], i);

    // Repeat: 5,5,6,6,7,7,5,5,6 with no done, then abort mid-dwell.
    rv = mk(5, 7, 1, 2, 1, 44, 0, 0, 0, 0, 0);
    rep_exp = '{10'd5, 10'd5, 10'd6, 10'd6, 10'd7, 10'd7, 10'd5, 10'd5, 10'd6};
    issue(rv, 1'b1);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("rep_c%0d", c), 32'(phase), 32'(rep_exp[c]));
      check("rep_no_done", {wave_en, done}, 2'b10);
    end
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_state", {wave_en, busy, done, cmd_ready}, 4'b0001);

    // Constant tone: inc=0 holds start well past 1000 cycles.
    rv = mk(300, 500, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    issue(rv, 1'b0);
    bad = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (phase !== 10'd300 || wave_en !== 1'b1 || done !== 1'b0) bad++;
    end
    check("const_tone_bad_cycles", 32'(bad), 0);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("const_abort", {wave_en, busy, done}, 3'b000);

    // Valid together with abort in IDLE must not be accepted.
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; abort = 1'b1; cmd_start = 10'd50; cmd_stop = 10'd60;
    cmd_inc = 10'd1; cmd_dwell = 16'd1;
    @(negedge clk);
    check("abort_blocks_ready", 32'(cmd_ready), 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_blocks_accept", {busy, wave_en}, 2'b00);

    // Asynchronous reset mid-sweep clears everything without a done pulse.
    issue(vecs[0], 1'b0);
    repeat (5) @(negedge clk);
    check("pre_reset_phase", 32'(phase), 20);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {phase, gain, duty, wave_en, busy, done}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_oneshot(vecs[0], 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
